// File: rtl/fir_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_stream_ctrl: credit-based sequencer around a no-backpressure FIR,     |
// | with issue spacing, FWFT result FIFO and enable-driven run/drain/idle.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fir_stream_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int RESULT_WIDTH = 26,
    parameter int FIFO_DEPTH   = 16,
    parameter int MIN_GAP      = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    fir_valid_in,
    output logic [DATA_WIDTH-1:0]   fir_din,
    input  logic                    fir_valid_out,
    input  logic [RESULT_WIDTH-1:0] fir_dout,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [RESULT_WIDTH-1:0] m_data,
    output logic                    busy,
    output logic                    err_overflow,
    output logic                    err_unexpected
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           inflight, inflight_nxt;
    logic [CW-1:0]           wr_ptr, rd_ptr, fifo_count, count_nxt;
    logic [GW-1:0]           gap;
    logic [CW:0]             credit_sum;
    logic [RESULT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                    fifo_full, fifo_empty;
    logic                    accept, pop, push, overflow;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};

    assign s_ready  = (state == RUN) && (gap == '0) && (credit_sum < (CW+1)'(FIFO_DEPTH));
    assign accept   = s_valid && s_ready;
    assign m_valid  = !fifo_empty;
    assign pop      = m_valid && m_ready;
    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign push     = fir_valid_out && (!fifo_full || pop);
    assign overflow = fir_valid_out && fifo_full && !pop;
    assign m_data   = m_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign busy     = (state != IDLE) || (inflight != '0) || !fifo_empty;

    assign count_nxt = fifo_count + CW'(push) - CW'(pop);

    always_comb begin
        inflight_nxt = inflight;
        if (accept && !fir_valid_out) begin
            inflight_nxt = inflight + CW'(1);
        end else if (!accept && fir_valid_out && (inflight != '0)) begin
            inflight_nxt = inflight - CW'(1);
        end
    end

    // Drain completion looks at next-cycle occupancy so IDLE coincides with the last pop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if ((inflight_nxt == '0) && (count_nxt == '0)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            inflight       <= '0;
            gap            <= '0;
            fir_valid_in   <= 1'b0;
            fir_din        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            err_overflow   <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            state        <= state_nxt;
            inflight     <= inflight_nxt;
            fir_valid_in <= accept;
            if (accept) begin
                fir_din <= s_data;
                gap     <= GW'(MIN_GAP);
            end else if (gap != '0) begin
                gap <= gap - GW'(1);
            end
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (pop)  rd_ptr <= rd_ptr + CW'(1);
            if (overflow) err_overflow <= 1'b1;
            if (fir_valid_out && (inflight == '0)) err_unexpected <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= fir_dout;
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_stream_ctrl: randomized bench with a fixed-latency filter stub and |
// | queue-based scoreboard of accepted samples and FIFO contents.             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_fir_stream_ctrl;

    localparam int DW    = 16;
    localparam int RW    = 26;
    localparam int DEPTH = 16;
    localparam int LAT   = 8;

    logic          clk = 1'b0;
    logic          rst, enable, s_valid, m_ready, inj;
    logic [DW-1:0] s_data;
    logic [RW-1:0] inj_data;
    logic          s_ready, fir_valid_in, fir_valid_out, m_valid, busy, err_overflow, err_unexpected;
    logic [DW-1:0] fir_din;
    logic [RW-1:0] fir_dout, m_data;

    logic          enable2, s_valid2, m_ready2, fvo2;
    logic [DW-1:0] s_data2;
    logic [RW-1:0] fdout2;
    logic          s_ready2, fir_valid_in2, m_valid2, busy2, eo2, eu2;
    logic [DW-1:0] fir_din2;
    logic [RW-1:0] m_data2;

    int n_vec = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    logic exp_ovf = 1'b0;
    logic exp_unexp = 1'b0;
    logic [DW-1:0] acc_q[$];
    logic [RW-1:0] fifo_q[$];
    logic [DW-1:0] g_q[$];

    logic [LAT-1:0] pv;
    logic [RW-1:0]  pd [LAT];

    always #5 clk = ~clk;

    fir_stream_ctrl #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .FIFO_DEPTH(DEPTH), .MIN_GAP(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fir_valid_in(fir_valid_in), .fir_din(fir_din), .fir_valid_out(fir_valid_out), .fir_dout(fir_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
        .err_overflow(err_overflow), .err_unexpected(err_unexpected));

    fir_stream_ctrl #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .FIFO_DEPTH(DEPTH), .MIN_GAP(2)) dut_gap (
        .clk(clk), .rst(rst), .enable(enable2), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .fir_valid_in(fir_valid_in2), .fir_din(fir_din2), .fir_valid_out(fvo2), .fir_dout(fdout2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .busy(busy2),
        .err_overflow(eo2), .err_unexpected(eu2));

    function automatic logic [RW-1:0] filt(input logic [DW-1:0] x);
        return {10'd0, x} * 26'd5 + 26'd3;
    endfunction

    // Fixed-latency filter stand-in; spurious results can be injected on top of it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], fir_valid_in};
            pd[0] <= filt(fir_din);
            for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
        end
    end
    assign fir_valid_out = pv[LAT-1] | inj;
    assign fir_dout      = inj ? inj_data : pd[LAT-1];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: compare against model state, then fold in this cycle's events.
    always @(negedge clk) begin : monitor
        logic pop;
        int   n_in;
        if (rst) begin
            check_value("m_valid", m_valid, fifo_q.size() != 0);
            if (fifo_q.size() != 0) check_value("m_data", m_data, fifo_q[0]);
            else                    check_value("m_data_idle", m_data, 0);
            check_value("err_overflow", err_overflow, exp_ovf);
            check_value("err_unexpected", err_unexpected, exp_unexp);
            if (s_ready) check_value("credit", acc_q.size() + fifo_q.size() < DEPTH, 1);
            pop  = m_valid && m_ready;
            n_in = fifo_q.size();
            if (pop) begin
                void'(fifo_q.pop_front());
                pop_cnt++;
            end
            if (fir_valid_out) begin
                if (acc_q.size() == 0) exp_unexp = 1'b1;
                else check_value("fir_path", fir_dout, filt(acc_q.pop_front()));
                if (n_in < DEPTH || pop) fifo_q.push_back(fir_dout);
                else exp_ovf = 1'b1;
            end
            if (s_valid && s_ready) begin
                acc_q.push_back(s_data);
                acc_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_step();
        logic took;
        took = s_valid && s_ready;
        step();
        if (took) s_data = DW'($urandom);
    endtask

    task automatic wait_drained(input string tag);
        int k;
        k = 0;
        while ((acc_q.size() != 0 || fifo_q.size() != 0) && k < 500) begin
            drive_step();
            k++;
        end
        check_value(tag, (acc_q.size() == 0) && (fifo_q.size() == 0), 1);
    endtask

    task automatic check_reset_outputs(input string ph);
        check_value({ph, "_s_ready"}, s_ready, 0);
        check_value({ph, "_fir_valid_in"}, fir_valid_in, 0);
        check_value({ph, "_fir_din"}, fir_din, 0);
        check_value({ph, "_m_valid"}, m_valid, 0);
        check_value({ph, "_m_data"}, m_data, 0);
        check_value({ph, "_busy"}, busy, 0);
        check_value({ph, "_err_overflow"}, err_overflow, 0);
        check_value({ph, "_err_unexpected"}, err_unexpected, 0);
    endtask

    initial begin : main
        int acc0, pop0, k, n2;
        logic took2, exp_v;
        rst = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = DW'($urandom);
        m_ready = 1'b0; inj = 1'b0; inj_data = '0;
        enable2 = 1'b0; s_valid2 = 1'b0; s_data2 = '0; m_ready2 = 1'b0; fvo2 = 1'b0; fdout2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        step();
        step();
        check_value("idle_ready", s_ready, 0);

        // Back-to-back streaming, 100 samples
        enable = 1'b1; m_ready = 1'b1; s_valid = 1'b1;
        step();
        acc0 = acc_cnt; pop0 = pop_cnt;
        for (int i = 0; i < 100; i++) begin
            check_value("b2b_ready", s_ready, 1);
            drive_step();
            check_value("b2b_valid_in", fir_valid_in, 1);
        end
        s_valid = 1'b0;
        wait_drained("b2b_drain");
        check_value("b2b_accepts", acc_cnt - acc0, 100);
        check_value("b2b_pops", pop_cnt - pop0, 100);

        // Issue spacing with MIN_GAP = 2
        s_data2 = DW'($urandom); s_valid2 = 1'b1; enable2 = 1'b1; n2 = 0;
        for (int c = 1; c <= 30; c++) begin
            took2 = s_valid2 && s_ready2;
            if (took2) g_q.push_back(s_data2);
            step();
            if (took2) begin
                n2++;
                s_data2 = DW'($urandom);
                if (n2 == 10) s_valid2 = 1'b0;
            end
            check_value("gap_ready", s_ready2, (c - 1) % 3 == 0);
            exp_v = (c >= 2) && ((c - 2) % 3 == 0) && (c <= 29);
            check_value("gap_valid_in", fir_valid_in2, exp_v);
            if (exp_v && g_q.size() != 0) check_value("gap_din", fir_din2, g_q.pop_front());
        end
        check_value("gap_count", n2, 10);
        enable2 = 1'b0;

        // Backpressure: downstream stalled
        m_ready = 1'b0; s_valid = 1'b1; acc0 = acc_cnt; pop0 = pop_cnt;
        for (int i = 0; i < 60; i++) drive_step();
        check_value("bp_accepts", acc_cnt - acc0, DEPTH);
        check_value("bp_ready", s_ready, 0);
        check_value("bp_overflow", err_overflow, 0);
        m_ready = 1'b1; k = 0;
        while (acc_cnt - acc0 < 40 && k < 300) begin
            drive_step();
            k++;
        end
        s_valid = 1'b0;
        check_value("bp_total_accepts", acc_cnt - acc0, 40);
        wait_drained("bp_drain");
        check_value("bp_pops", pop_cnt - pop0, 40);

        // Drain with 5 in flight and 3 buffered
        m_ready = 1'b0; s_valid = 1'b1; acc0 = acc_cnt; pop0 = pop_cnt; k = 0;
        while (acc_cnt - acc0 < 8 && k < 50) begin
            drive_step();
            k++;
        end
        s_valid = 1'b0; k = 0;
        while (fifo_q.size() != 3 && k < 50) begin
            step();
            k++;
        end
        check_value("drain_setup_inflight", acc_q.size(), 5);
        enable = 1'b0;
        step();
        check_value("drain_ready_t1", s_ready, 0);
        s_valid = 1'b1; m_ready = 1'b1; k = 0;
        while (k < 200) begin
            drive_step();
            k++;
            if (fifo_q.size() == 0 && acc_q.size() == 0) break;
            check_value("drain_no_accept", s_ready, 0);
        end
        check_value("drain_busy", busy, 0);
        s_valid = 1'b0;
        check_value("drain_pops", pop_cnt - pop0, 8);
        check_value("drain_accepts", acc_cnt - acc0, 8);

        // Error injection
        enable = 1'b1;
        step();
        step();
        pop0 = pop_cnt;
        inj = 1'b1; inj_data = RW'($urandom);
        step();
        inj = 1'b0;
        step();
        check_value("unexp_flag", err_unexpected, 1);
        wait_drained("unexp_drain");
        check_value("unexp_delivered", pop_cnt - pop0, 1);
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            inj = 1'b1; inj_data = RW'($urandom);
            step();
        end
        inj = 1'b0;
        step();
        check_value("ovf_flag", err_overflow, 1);
        check_value("unexp_sticky", err_unexpected, 1);
        m_ready = 1'b1; pop0 = pop_cnt;
        wait_drained("ovf_drain");
        check_value("ovf_delivered", pop_cnt - pop0, DEPTH);

        // Reset with the FIFO half full
        m_ready = 1'b0; s_valid = 1'b1; acc0 = acc_cnt; k = 0;
        while (acc_cnt - acc0 < 8 && k < 50) begin
            drive_step();
            k++;
        end
        s_valid = 1'b0; k = 0;
        while (acc_q.size() != 0 && k < 50) begin
            step();
            k++;
        end
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        acc_q.delete(); fifo_q.delete(); exp_ovf = 1'b0; exp_unexp = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        check_value("rst_fifo_empty", m_valid, 0);

        // Randomized traffic after reset
        acc0 = acc_cnt; pop0 = pop_cnt;
        for (int i = 0; i < 400; i++) begin
            if (!(s_valid && !s_ready)) s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            drive_step();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        wait_drained("rand_drain");
        check_value("rand_some_traffic", acc_cnt - acc0 > 20, 1);
        check_value("rand_all_delivered", pop_cnt - pop0, acc_cnt - acc0);

        enable = 1'b0;
        step();
        step();
        check_value("final_busy", busy, 0);
        check_value("final_err_overflow", err_overflow, 0);
        check_value("final_err_unexpected", err_unexpected, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fir_stream_ctrl.md
# fir_stream_ctrl

Streaming sequencer that sits in front of and behind one FIR filter instance. The filter has no backpressure. This block accepts bursty upstream samples over a valid/ready handshake and issues them to the filter's `valid_in`/`din` with an optional minimum spacing. It captures every `valid_out`/`dout` into an output FIFO and uses credit accounting so that the FIFO can never overflow, even when downstream stalls. An enable-driven state machine provides clean start, drain and stop.

## Interface
Parameters:
- `DATA_WIDTH`, 16, sample width; matches the filter input width.
- `RESULT_WIDTH`, 26, result width; matches the filter output width.
- `FIFO_DEPTH`, 16, output FIFO entries; power of 2, ≥ 2.
- `MIN_GAP`, 0, minimum idle cycles between consecutive issues to the filter (0 allows back-to-back issues).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `enable` in 1: level; 1 = run, 0 = drain then idle.
- `s_valid` in 1: upstream sample valid.
- `s_ready` out 1: upstream ready.
- `s_data` in DATA_WIDTH: upstream sample.
- `fir_valid_in` out 1: connects to the filter `valid_in`.
- `fir_din` out DATA_WIDTH: connects to the filter `din`.
- `fir_valid_out` in 1: from the filter `valid_out`.
- `fir_dout` in RESULT_WIDTH: from the filter `dout`.
- `m_valid` out 1: downstream result valid.
- `m_ready` in 1: downstream ready.
- `m_data` out RESULT_WIDTH: downstream result.
- `busy` out 1: 1 when the state is not IDLE, or `inflight` ≠ 0, or the FIFO is non-empty.
- `err_overflow` out 1: sticky; a filter result arrived while the FIFO was full.
- `err_unexpected` out 1: sticky; a filter result arrived while `inflight` = 0.

## Operation
- **Reset values.** State = IDLE. `inflight` = 0. Gap counter = 0. FIFO empty. All outputs are 0: `s_ready`, `fir_valid_in`, `fir_din`, `m_valid`, `m_data`, `busy`, and both `err_*` flags.
- **States.**
  - IDLE → RUN when `enable` = 1.
  - RUN → DRAIN when `enable` = 0.
  - DRAIN → RUN when `enable` = 1.
  - DRAIN → IDLE when `inflight` = 0 and the FIFO is empty.
- **Acceptance.** `s_ready` = (state == RUN) && (gap == 0) && (`inflight` + `fifo_count` < `FIFO_DEPTH`).
  - All three terms are registered state. `s_ready` never depends on `s_valid`.
- **Accept.** An accept is `s_valid && s_ready`. On an accept:
  - Register `s_data` into `fir_din`.
  - Pulse `fir_valid_in` for 1 cycle.
  - Increment `inflight`.
  - Load the gap counter with `MIN_GAP`.
  - When there is no accept, `fir_din` holds its last value.
- **Gap counter.** Decrements by 1 each cycle while it is non-zero.
- **Result capture.** On `fir_valid_out`:
  - `inflight` decrements, saturating at 0. If `inflight` was 0, set `err_unexpected` and still write the result if there is room.
  - Write `fir_dout` to the FIFO. If the FIFO is full and no read occurs that cycle, drop the word and set `err_overflow`.
- **Simultaneous accept and return.** `inflight` is unchanged.
- **Simultaneous FIFO read and write when full.** Both complete and the count is unchanged; no error is raised.
- **FIFO read side.**
  - The FIFO is first-word-fall-through. `m_valid` = non-empty, and `m_data` = head word; `m_data` is forced to 0 while `m_valid` = 0.
  - A pop occurs on `m_valid && m_ready`.
  - `m_valid` and `m_data` stay stable until the pop.
- **Pointer widths.** FIFO pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap naturally.
- **Counter widths.** `inflight` and `fifo_count` are log2(`FIFO_DEPTH`)+1 bits wide.
- **Error flags.** `err_*` flags clear only on `rst`.
- **Reset during operation.** `rst` clears all state immediately, including FIFO contents and `inflight`. Outputs take their reset values asynchronously.

## Timing
- `enable` rises at cycle t: state = RUN at t+1, and `s_ready` can first be 1 at t+1.
- Accept at cycle t: `fir_valid_in` = 1 and `fir_din` = sample at t+1.
- `fir_valid_out` at cycle u: `m_valid` = 1 with that word at u+1 (FIFO previously empty).
- Throughput limit: one accept every `MIN_GAP`+1 cycles.
- Credit bound: `inflight` + `fifo_count` ≤ `FIFO_DEPTH` at all times when the filter behaves correctly. Therefore `err_overflow` can never be set in correct operation, regardless of filter latency.
- `enable` falls at cycle t: state = DRAIN at t+1, and `s_ready` = 0 from t+1. A handshake at cycle t still completes.
- Last result popped at cycle v with `inflight` = 0: state = IDLE at v+1 and `busy` = 0 at v+1.

## Test plan
- **Back-to-back streaming.** `MIN_GAP`=0, filter model latency 8, 100 samples with `m_ready`=1.
  - Expect 100 contiguous `fir_valid_in` pulses and 100 results in order.
  - Expect no `err_*` set and `busy`=0 afterwards.
- **Spacing.** `MIN_GAP`=2, `s_valid` held at 1 for 10 samples.
  - Expect `fir_valid_in` exactly every 3rd cycle.
  - Expect `s_ready` high 1 cycle in 3.
- **Backpressure.** `FIFO_DEPTH`=16, `m_ready`=0, 40 samples offered.
  - Expect exactly 16 accepts, then `s_ready` held at 0 and no `err_overflow`.
  - Release `m_ready`: expect all 40 results delivered in order.
- **Drain.** Drop `enable` with 5 samples in flight and 3 words in the FIFO.
  - Expect no further accepts and all 8 results delivered.
  - Expect IDLE and `busy`=0 one cycle after the last pop.
- **Error injection.** Inject a spurious `fir_valid_out` with `inflight`=0.
  - Expect `err_unexpected`=1, sticky, and the word delivered.
  - Force a write while the FIFO is full with no pop: expect `err_overflow`=1 and the word dropped.
- **Reset mid-operation.** Assert `rst` low with the FIFO half full.
  - Expect all outputs 0 immediately and an empty FIFO.
  - Expect `inflight`=0 and normal operation after release.
